// File: rtl/blinds_actuator_if.sv
// Command/status bundle between the blinds controller and the motor actuator.
interface blinds_actuator_if;
    logic [1:0] target;
    logic       stop;
    logic       motor_up;
    logic       motor_down;
    logic [3:0] position;
    logic       busy;
    logic       at_target;

    modport master (
        output target, stop,
        input  motor_up, motor_down, position, busy, at_target
    );

    modport slave (
        input  target, stop,
        output motor_up, motor_down, position, busy, at_target
    );
endinterface

// File: rtl/blinds_actuator.sv
// Blinds motor actuator: debounces the commanded level, then steps the motor toward it,
// inserting a motor-off dead time before re-planning mid-motion.
module blinds_actuator #(
    parameter int SETTLE_CYCLES = 4,
    parameter int STEP_CYCLES   = 8,
    parameter int POS_PER_LEVEL = 4,
    parameter int DEAD_CYCLES   = 2
) (
    input logic              clk,
    input logic              rst,
    blinds_actuator_if.slave bus
);
    localparam int MAX_POS = 3 * POS_PER_LEVEL;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(STEP_CYCLES + 1);
    localparam int DW = $clog2(DEAD_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, MOVE_UP, MOVE_DOWN, DEAD} state_t;

    state_t        state;
    logic [1:0]    cand;
    logic [3:0]    goal;
    logic [3:0]    position;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] step_cnt;
    logic [DW-1:0] dead_cnt;
    logic          motor_up;
    logic          motor_down;
    logic [3:0]    tgt_pos;
    logic [3:0]    cand_pos;

    assign tgt_pos  = 4'(32'(bus.target) * POS_PER_LEVEL);
    assign cand_pos = 4'(32'(cand) * POS_PER_LEVEL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cand       <= 2'b00;
            goal       <= 4'd0;
            position   <= 4'd0;
            settle_cnt <= '0;
            step_cnt   <= '0;
            dead_cnt   <= '0;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
        end else if (bus.stop) begin
            state      <= IDLE;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            settle_cnt <= '0;
            step_cnt   <= '0;
            dead_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tgt_pos != position) begin
                        state      <= SETTLE;
                        cand       <= bus.target;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    // Any wobble on target restarts the stability window.
                    if (bus.target != cand) begin
                        cand       <= bus.target;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SW'(SETTLE_CYCLES)) begin
                        goal     <= cand_pos;
                        step_cnt <= '0;
                        if (cand_pos > position) begin
                            state      <= MOVE_DOWN;
                            motor_down <= 1'b1;
                        end else if (cand_pos < position) begin
                            state    <= MOVE_UP;
                            motor_up <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (tgt_pos != goal) begin
                        // Re-plan only after the motor has been off for the dead time.
                        state      <= DEAD;
                        motor_up   <= 1'b0;
                        motor_down <= 1'b0;
                        step_cnt   <= '0;
                        dead_cnt   <= '0;
                    end else if (step_cnt == TW'(STEP_CYCLES - 1)) begin
                        step_cnt <= '0;
                        if (state == MOVE_DOWN) begin
                            if (position == 4'(MAX_POS)) begin
                                state      <= IDLE;
                                motor_down <= 1'b0;
                            end else begin
                                position <= position + 4'd1;
                                if (4'(position + 4'd1) == goal) begin
                                    state      <= IDLE;
                                    motor_down <= 1'b0;
                                end
                            end
                        end else begin
                            if (position == 4'd0) begin
                                state    <= IDLE;
                                motor_up <= 1'b0;
                            end else begin
                                position <= position - 4'd1;
                                if (4'(position - 4'd1) == goal) begin
                                    state    <= IDLE;
                                    motor_up <= 1'b0;
                                end
                            end
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                DEAD: begin
                    if (dead_cnt == DW'(DEAD_CYCLES - 1)) begin
                        state      <= SETTLE;
                        cand       <= bus.target;
                        settle_cnt <= '0;
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    motor_up   <= 1'b0;
                    motor_down <= 1'b0;
                end
            endcase
        end
    end

    assign bus.motor_up   = motor_up;
    assign bus.motor_down = motor_down;
    assign bus.position   = position;
    assign bus.busy       = (state != IDLE);
    assign bus.at_target  = (state == IDLE) && (position == tgt_pos);
endmodule

// File: tb/tb_blinds_actuator.sv
// Scoreboard bench: a timestamp-based reference model predicts every cycle's outputs;
// a monitor compares the DUT against the queued predictions.
module tb_blinds_actuator;
    localparam int SETTLE  = 4;
    localparam int STEP    = 8;
    localparam int PPL     = 4;
    localparam int DEADC   = 2;
    localparam int MAXP    = 3 * PPL;

    localparam int P_IDLE = 0, P_SETTLE = 1, P_UP = 2, P_DOWN = 3, P_DEAD = 4;

    typedef struct packed {
        logic       up;
        logic       down;
        logic [3:0] pos;
        logic       busy;
        logic       at;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    blinds_actuator_if bif();

    blinds_actuator #(
        .SETTLE_CYCLES(SETTLE), .STEP_CYCLES(STEP),
        .POS_PER_LEVEL(PPL), .DEAD_CYCLES(DEADC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    always #5 clk = ~clk;

    snap_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: phase plus the edge index at which the phase began.
    int now = 0, ph = P_IDLE, pos = 0, goal = 0, cand = 0, since = 0;

    task automatic model_edge(input bit r, input int t, input bit s);
        int nxt;
        now++;
        if (r) begin
            ph = P_IDLE; pos = 0; goal = 0; cand = 0;
        end else if (s) begin
            ph = P_IDLE;
        end else begin
            case (ph)
                P_IDLE:
                    if (t * PPL != pos) begin ph = P_SETTLE; cand = t; since = now; end
                P_SETTLE:
                    if (t != cand) begin
                        cand = t; since = now;
                    end else if (now - since > SETTLE) begin
                        goal = cand * PPL; since = now;
                        ph = (goal > pos) ? P_DOWN : (goal < pos) ? P_UP : P_IDLE;
                    end
                P_UP, P_DOWN:
                    if (t * PPL != goal) begin
                        ph = P_DEAD; since = now;
                    end else if ((now - since) % STEP == 0) begin
                        nxt = pos + ((ph == P_DOWN) ? 1 : -1);
                        if (nxt < 0 || nxt > MAXP) ph = P_IDLE;
                        else begin
                            pos = nxt;
                            if (pos == goal) ph = P_IDLE;
                        end
                    end
                P_DEAD:
                    if (now - since == DEADC) begin ph = P_SETTLE; cand = t; since = now; end
                default: ph = P_IDLE;
            endcase
        end
    endtask

    function automatic snap_t predict(input int t);
        snap_t e;
        e.up   = (ph == P_UP);
        e.down = (ph == P_DOWN);
        e.pos  = 4'(pos);
        e.busy = (ph != P_IDLE);
        e.at   = (ph == P_IDLE) && (pos == t * PPL);
        return e;
    endfunction

    task automatic apply(input bit r, input int t, input bit s, input int n);
        repeat (n) begin
            @(negedge clk);
            rst        = r;
            bif.target = 2'(t);
            bif.stop   = s;
            model_edge(r, t, s);
            q.push_back(predict(t));
        end
    endtask

    // Monitor: the DUT presents a fresh output snapshot after every edge.
    initial begin
        snap_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{bif.motor_up, bif.motor_down, bif.position, bif.busy, bif.at_target};
                checks++;
                if (a !== e) begin
                    errors++;
                    if (errors <= 30)
                        $display("FAIL snap cyc=%0d act up=%b dn=%b pos=%0d busy=%b at=%b exp up=%b dn=%b pos=%0d busy=%b at=%b",
                                 cyc, a.up, a.down, a.pos, a.busy, a.at,
                                 e.up, e.down, e.pos, e.busy, e.at);
                end
                checks++;
                if (bif.motor_up && bif.motor_down) begin
                    errors++;
                    $display("FAIL motor_excl cyc=%0d act both high exp at most one", cyc);
                end
            end
        end
    end

    initial begin
        bif.target = 2'b00;
        bif.stop   = 1'b0;
        // reset, then full travel down and partial travel up
        apply(1, 0, 0, 2);
        apply(0, 0, 0, 3);
        apply(0, 3, 0, 120);
        apply(0, 1, 0, 80);
        // target chatter during settle, then a stable level
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 0, 2);
            apply(0, 2, 0, 2);
        end
        apply(0, 2, 0, 60);
        // reverse mid-motion at position 6
        apply(1, 0, 0, 1);
        apply(0, 3, 0, 5 + 6 * STEP + 3);
        apply(0, 0, 0, 90);
        // manual stop at position 5, then resume
        apply(0, 3, 0, 5 + 5 * STEP + 2);
        apply(0, 3, 1, 10);
        apply(0, 3, 0, 80);
        // stop asserted while reset is active
        apply(1, 2, 1, 2);
        apply(0, 2, 0, 70);
        // randomized segments
        for (int i = 0; i < 250; i++)
            apply(($urandom_range(0, 60) == 0), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0), $urandom_range(1, 40));
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d pending exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/blinds_actuator.md
BLINDS_ACTUATOR -- requirements
Module: blinds_actuator

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: number of cycles target must be held stable before motion starts (>=1).
REQ-002 Parameter STEP_CYCLES, default 8: motor-on cycles per one position unit (>=1).
REQ-003 Parameter POS_PER_LEVEL, default 4: position units per command level; MAX_POS = 3*POS_PER_LEVEL.
REQ-004 Parameter DEAD_CYCLES, default 2: motor-off cycles forced before any re-plan during motion (>=1).
REQ-005 clk  input  1  single system clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 target  input  2  commanded blind level from the blinds controller: 00 open ... 11 fully closed.
REQ-008 stop  input  1  manual stop; level-sensitive, highest priority after rst.
REQ-009 motor_up  output  1  registered drive toward open (position decreasing).
REQ-010 motor_down  output  1  registered drive toward closed (position increasing).
REQ-011 position  output  4  registered current position, 0..MAX_POS.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 at_target  output  1  high when state is IDLE and position == target*POS_PER_LEVEL.

Function
REQ-014 States: IDLE, SETTLE, MOVE_UP, MOVE_DOWN, DEAD; encoding is free.
REQ-015 motor_up and motor_down SHALL never be high in the same cycle; motor_down high only in MOVE_DOWN, motor_up only in MOVE_UP.
REQ-016 IDLE: if stop==0 and target*POS_PER_LEVEL != position -> SETTLE; latch cand=target, settle counter=0.
REQ-017 SETTLE: target != cand -> relatch cand, counter=0, stay; else counter+1 each cycle.
REQ-018 SETTLE exit after SETTLE_CYCLES consecutive stable cycles: goal=cand*POS_PER_LEVEL; goal>position -> MOVE_DOWN, goal<position -> MOVE_UP, equal -> IDLE; step timer=0.
REQ-019 MOVE_*: step timer counts 0..STEP_CYCLES-1; on terminal count position +1 (DOWN) or -1 (UP), timer=0.
REQ-020 MOVE_*: on the cycle position is updated to equal goal -> IDLE; motor output low from the following cycle.
REQ-021 MOVE_*: target*POS_PER_LEVEL != goal -> DEAD, motor off, step timer cleared (partial step discarded, position unchanged).
REQ-022 DEAD: hold DEAD_CYCLES cycles, then -> SETTLE with cand=target, counter=0.
REQ-023 stop==1 in any state -> IDLE next edge, motors low, position held; IDLE SHALL not exit while stop==1.
REQ-024 position SHALL saturate: never below 0, never above MAX_POS; a step that would cross a limit -> IDLE without updating.
REQ-025 Latency: target change sampled in IDLE -> first motor cycle exactly SETTLE_CYCLES+1 edges later.
REQ-026 Full travel 0 -> MAX_POS SHALL take MAX_POS*STEP_CYCLES motor-on cycles.

Reset
REQ-027 rst==1 at an edge: state IDLE, position=0, motor_up=0, motor_down=0, busy=0, all counters and goal=0, cand=00.
REQ-028 rst SHALL override stop and any in-progress motion in the same edge; at_target after reset follows REQ-013 (1 iff target==00).

Verification (defaults)
REQ-029 rst, target=00 -> position=0, motors 0, busy=0, at_target=1.
REQ-030 target 00->11 held -> motor_down rises 5 edges later, stays 96 cycles, position=12, then IDLE, at_target=1.
REQ-031 position=12, target 11->01 held -> motor_up for 64 cycles, final position=4.
REQ-032 In SETTLE, target toggles 01/10 every 2 cycles -> no motor activity, busy=1; after holding 10 for 4 cycles motion starts.
REQ-033 Mid MOVE_DOWN at position 6, target 11->00 -> motors low 2 cycles (DEAD), 4 SETTLE cycles, then motor_up, reaches 0.
REQ-034 stop=1 during motion at position 5 -> motors low next cycle, position stays 5 while stop=1; stop=0 -> resumes via SETTLE.
